// File: rtl/gray_rx_checker.sv
// gray_rx_checker: receive-side checker for a Gray-coded counter stream.
// Converts each accepted Gray sample to binary, classifies the step against
// the previous sample (hold / up / down / illegal) and tracks lock.
// Optional feature macro: GRAY_ERR_CNT_EN enables the saturating error
// counter on err_cnt_o; when undefined err_cnt_o is tied to zero.
module gray_rx_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] g_i,
  input  logic             g_vld_i,
  output logic [WIDTH-1:0] b_o,
  output logic             b_vld_o,
  output logic             up_o,
  output logic             down_o,
  output logic             err_o,
  output logic             locked_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } st_t;

  localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Hamming weight clipped to 0, 1 or 2 (2 meaning "two or more").
  function automatic logic [1:0] dist_class(input logic [WIDTH-1:0] d);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i] && (c != 2'd2)) begin
        c = c + 2'd1;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  st_t              st_q;
  logic [3:0]       good_cnt_q;
  logic [WIDTH-1:0] g_prev_q;
  logic [WIDTH-1:0] b_prev_q;
  logic             b_vld_q;
  logic             up_q;
  logic             down_q;
  logic             err_q;
  logic             locked_q;

  logic [WIDTH-1:0] b_new_s;
  logic [1:0]       dist_s;
  logic             step_up_s;
  logic             err_ev_s;
  logic [3:0]       good_next_s;

  // Combinational conversion and step classification of the incoming sample.
  always_comb begin
    b_new_s     = gray2bin(g_i);
    dist_s      = dist_class(g_i ^ g_prev_q);
    step_up_s   = (b_new_s == (b_prev_q + ONE_C));
    err_ev_s    = g_vld_i && (st_q != ST_EMPTY) && (dist_s == 2'd2);
    good_next_s = good_cnt_q + 4'd1;
  end

  // Lock FSM with registered sample history and step pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_EMPTY;
      good_cnt_q <= 4'd0;
      g_prev_q   <= {WIDTH{1'b0}};
      b_prev_q   <= {WIDTH{1'b0}};
      b_vld_q    <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      b_vld_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      err_q   <= 1'b0;
      if (g_vld_i) begin
        // Even illegal samples are adopted so the checker resynchronises.
        g_prev_q <= g_i;
        b_prev_q <= b_new_s;
        b_vld_q  <= 1'b1;
        case (st_q)
          ST_EMPTY: begin
            st_q       <= ST_ACQUIRE;
            good_cnt_q <= 4'd0;
            locked_q   <= 1'b0;
          end
          ST_ACQUIRE: begin
            if (err_ev_s) begin
              err_q      <= 1'b1;
              good_cnt_q <= 4'd0;
            end else if (dist_s == 2'd1) begin
              up_q       <= step_up_s;
              down_q     <= !step_up_s;
              good_cnt_q <= good_next_s;
              if (good_next_s == LOCK_C) begin
                st_q     <= ST_LOCKED;
                locked_q <= 1'b1;
              end else begin
                st_q     <= ST_ACQUIRE;
              end
            end else begin
              good_cnt_q <= good_cnt_q;
            end
          end
          ST_LOCKED: begin
            if (err_ev_s) begin
              err_q      <= 1'b1;
              st_q       <= ST_ACQUIRE;
              locked_q   <= 1'b0;
              good_cnt_q <= 4'd0;
            end else if (dist_s == 2'd1) begin
              up_q   <= step_up_s;
              down_q <= !step_up_s;
            end else begin
              st_q <= ST_LOCKED;
            end
          end
          default: begin
            st_q       <= ST_EMPTY;
            good_cnt_q <= 4'd0;
            locked_q   <= 1'b0;
          end
        endcase
      end else begin
        st_q <= st_q;
      end
    end
  end

`ifdef GRAY_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  // Saturating count of illegal steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= {ERR_W{1'b0}};
    end else if (err_ev_s && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = {ERR_W{1'b0}};
`endif

  assign b_o      = b_prev_q;
  assign b_vld_o  = b_vld_q;
  assign up_o     = up_q;
  assign down_o   = down_q;
  assign err_o    = err_q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_gray_rx_checker.sv
// Self-checking bench for gray_rx_checker: reference model feeds a scoreboard
// queue; a monitor pops one entry per b_vld_o pulse and compares.
module tb_gray_rx_checker;

  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       g_i = 4'd0;
  logic             g_vld_i = 1'b0;
  logic [3:0]       b_o;
  logic             b_vld_o;
  logic             up_o;
  logic             down_o;
  logic             err_o;
  logic             locked_o;
  logic [ERR_W-1:0] err_cnt_o;

  gray_rx_checker #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .g_i(g_i), .g_vld_i(g_vld_i),
    .b_o(b_o), .b_vld_o(b_vld_o), .up_o(up_o), .down_o(down_o),
    .err_o(err_o), .locked_o(locked_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       b;
    logic             up;
    logic             down;
    logic             err;
    logic             locked;
    logic [ERR_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int               m_st   = 0;   // 0 empty, 1 acquire, 2 locked
  int               m_good = 0;
  logic [3:0]       m_gp   = 4'd0;
  logic [3:0]       m_bp   = 4'd0;
  logic [ERR_W-1:0] m_cnt  = '0;

`ifdef GRAY_ERR_CNT_EN
  localparam logic [ERR_W-1:0] CNT_ONE = 2'd1;
  localparam logic [ERR_W-1:0] CNT_SAT = 2'd3;
`else
  localparam logic [ERR_W-1:0] CNT_ONE = 2'd0;
  localparam logic [ERR_W-1:0] CNT_SAT = 2'd0;
`endif

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [3:0] gray(input int n);
    logic [3:0] v;
    v = n[3:0];
    return v ^ (v >> 1);
  endfunction

  // Drive one cycle of stimulus at the falling edge and update the model.
  task automatic drive(input logic [3:0] g, input logic v, input logic r);
    exp_t e;
    logic [3:0] b;
    int d;
    @(negedge clk);
    g_i = g; g_vld_i = v; rst = r;
    if (r) begin
      m_st = 0; m_good = 0; m_gp = 4'd0; m_bp = 4'd0; m_cnt = '0;
      sb_q.delete();
    end else if (v) begin
      b = g2b(g);
      e = '0;
      e.b = b;
      if (m_st == 0) begin
        m_st = 1; m_good = 0;
      end else begin
        d = $countones(g ^ m_gp);
        if (d == 1) begin
          if ((b - m_bp) == 4'd1) e.up = 1'b1;
          else e.down = 1'b1;
          if (m_st == 1) begin
            m_good++;
            if (m_good == LOCK_CNT) m_st = 2;
          end
        end else if (d >= 2) begin
          e.err = 1'b1; m_st = 1; m_good = 0;
`ifdef GRAY_ERR_CNT_EN
          if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
`endif
        end
      end
      e.locked = (m_st == 2);
      e.cnt = m_cnt;
      m_gp = g; m_bp = b;
      sb_q.push_back(e);
    end
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: one comparison per clock edge.
  always @(posedge clk) begin
    #1;
    n_tests++;
    if (b_vld_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: b_vld_o=1 b_o=%0d, required no output", b_o);
      end else begin
        mon_e = sb_q.pop_front();
        if ({b_o, up_o, down_o, err_o, locked_o, err_cnt_o} !== mon_e) begin
          n_fail++;
          $display("FAIL sb_compare: got b=%0d up=%0b dn=%0b err=%0b lk=%0b cnt=%0d, want b=%0d up=%0b dn=%0b err=%0b lk=%0b cnt=%0d",
                   b_o, up_o, down_o, err_o, locked_o, err_cnt_o,
                   mon_e.b, mon_e.up, mon_e.down, mon_e.err, mon_e.locked, mon_e.cnt);
        end
      end
    end else if (sb_q.size() != 0 || b_vld_o !== 1'b0 || up_o !== 1'b0 || down_o !== 1'b0 ||
                 err_o !== 1'b0 || locked_o !== (m_st == 2) || err_cnt_o !== m_cnt) begin
      n_fail++;
      $display("FAIL sb_idle: vld=%0b up=%0b dn=%0b err=%0b lk=%0b cnt=%0d pending=%0d, want no pulses lk=%0b cnt=%0d",
               b_vld_o, up_o, down_o, err_o, locked_o, err_cnt_o, sb_q.size(), (m_st == 2), m_cnt);
    end
  end

  task automatic test_reset;
    drive(4'd0, 1'b0, 1'b1);
    drive(4'd5, 1'b1, 1'b1);
    settle;
    n_tests++;
    if ({b_o, b_vld_o, up_o, down_o, err_o, locked_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: b=%0d vld=%0b up=%0b dn=%0b err=%0b lk=%0b cnt=%0d, want all 0",
               b_o, b_vld_o, up_o, down_o, err_o, locked_o, err_cnt_o);
    end
  endtask

  task automatic test_count;
    for (int n = 0; n < 20; n++) begin
      drive(gray(n), 1'b1, 1'b0);
      settle;
      n_tests++;
      if (b_o !== n[3:0] || up_o !== (n != 0) || err_o !== 1'b0 || locked_o !== (n >= 3)) begin
        n_fail++;
        $display("FAIL count[%0d]: b=%0d up=%0b err=%0b lk=%0b, want b=%0d up=%0b err=0 lk=%0b",
                 n, b_o, up_o, err_o, locked_o, n[3:0], (n != 0), (n >= 3));
      end
    end
  endtask

  task automatic test_wrap;
    for (int n = 4; n <= 16; n++) drive(gray(n), 1'b1, 1'b0);
    settle;
    n_tests++;
    if (b_o !== 4'd0 || up_o !== 1'b1 || err_o !== 1'b0 || locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: b=%0d up=%0b err=%0b lk=%0b, want b=0 up=1 err=0 lk=1", b_o, up_o, err_o, locked_o);
    end
  endtask

  task automatic test_down_reversal;
    logic [3:0] seq [5];
    logic       exp_up [5];
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0011, 4'b0001};
    exp_up = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      settle;
      n_tests++;
      if (up_o !== exp_up[i] || down_o !== !exp_up[i] || locked_o !== 1'b1) begin
        n_fail++;
        $display("FAIL down[%0d]: up=%0b dn=%0b lk=%0b, want up=%0b dn=%0b lk=1",
                 i, up_o, down_o, locked_o, exp_up[i], !exp_up[i]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [3:0] relock [3];
    relock = '{4'b0100, 4'b1100, 4'b1101};
    drive(4'b0011, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    drive(4'b0101, 1'b1, 1'b0);
    settle;
    n_tests++;
    if (err_o !== 1'b1 || locked_o !== 1'b0 || b_o !== 4'd6 || err_cnt_o !== CNT_ONE || up_o !== 1'b0 || down_o !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal: err=%0b lk=%0b b=%0d cnt=%0d up=%0b dn=%0b, want err=1 lk=0 b=6 cnt=%0d up=0 dn=0",
               err_o, locked_o, b_o, err_cnt_o, up_o, down_o, CNT_ONE);
    end
    for (int i = 0; i < 3; i++) begin
      drive(relock[i], 1'b1, 1'b0);
      settle;
      n_tests++;
      if (locked_o !== (i == 2) || up_o !== 1'b1) begin
        n_fail++;
        $display("FAIL relock[%0d]: lk=%0b up=%0b, want lk=%0b up=1", i, locked_o, up_o, (i == 2));
      end
    end
  endtask

  task automatic test_hold_gap;
    int pulses;
    drive(4'b1100, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0101, 1'b1, 1'b0);
    drive(4'b0111, 1'b1, 1'b0);
    drive(4'b0110, 1'b1, 1'b0);
    settle;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0110, (i == 0 || i == 4), 1'b0);
      settle;
      if (b_vld_o === 1'b1) pulses++;
      n_tests++;
      if (up_o !== 1'b0 || down_o !== 1'b0 || err_o !== 1'b0 || locked_o !== 1'b1 || b_o !== 4'd4) begin
        n_fail++;
        $display("FAIL hold[%0d]: up=%0b dn=%0b err=%0b lk=%0b b=%0d, want 0 0 0 1 b=4", i, up_o, down_o, err_o, locked_o, b_o);
      end
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL hold_pulses: got %0d b_vld_o pulses, want 2", pulses);
    end
    // Holds while acquiring must not advance lock progress.
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0011, 1'b1, 1'b0);
    settle;
    n_tests++;
    if (locked_o !== 1'b0) begin
      n_fail++;
      $display("FAIL acq_hold: lk=%0b after 2 legal steps and holds, want 0", locked_o);
    end
    drive(4'b0010, 1'b1, 1'b0);
    settle;
    n_tests++;
    if (locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL acq_lock: lk=%0b after 3rd legal step, want 1", locked_o);
    end
  endtask

  task automatic test_sat_reset;
    logic [3:0] bad [5];
    bad = '{4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0101};
    for (int i = 0; i < 5; i++) begin
      drive(bad[i], 1'b1, 1'b0);
      settle;
      n_tests++;
      if (err_o !== 1'b1 || locked_o !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_err[%0d]: err=%0b lk=%0b, want err=1 lk=0", i, err_o, locked_o);
      end
    end
    n_tests++;
    if (err_cnt_o !== CNT_SAT) begin
      n_fail++;
      $display("FAIL sat_cnt: got %0d, want %0d", err_cnt_o, CNT_SAT);
    end
    drive(4'b0011, 1'b1, 1'b1);
    settle;
    n_tests++;
    if ({b_o, b_vld_o, up_o, down_o, err_o, locked_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: b=%0d vld=%0b up=%0b dn=%0b err=%0b lk=%0b cnt=%0d, want all 0",
               b_o, b_vld_o, up_o, down_o, err_o, locked_o, err_cnt_o);
    end
    drive(4'b1111, 1'b1, 1'b0);
    settle;
    n_tests++;
    if (b_vld_o !== 1'b1 || err_o !== 1'b0 || up_o !== 1'b0 || down_o !== 1'b0 || b_o !== 4'd10) begin
      n_fail++;
      $display("FAIL first_after_rst: vld=%0b err=%0b up=%0b dn=%0b b=%0d, want vld=1 err=0 up=0 dn=0 b=10",
               b_vld_o, err_o, up_o, down_o, b_o);
    end
    drive(4'b0000, 1'b0, 1'b0);
    settle;
  endtask

  initial begin
    test_reset;
    test_count;
    test_wrap;
    test_down_reversal;
    test_illegal;
    test_hold_gap;
    test_sat_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_rx_checker.md
# gray_rx_checker

Receive-side companion to the 4-bit Gray-code counter in `top`. It samples a Gray-coded stream (such as `g_o`), converts each code to binary, and checks that every step is a legal single-bit change. It reports step direction, lock status and errors, so a bench or downstream logic can consume the counter output as a plain binary count.

## Interface
Parameters:
- `WIDTH`, 4: Gray/binary code width.
- `LOCK_CNT`, 3: consecutive legal steps required to declare lock; range 1..15.
- `ERR_W`, 8: error counter width.

Ports:
- `clk`, input, 1: sole clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `g_i`, input, WIDTH: Gray code sample.
- `g_vld_i`, input, 1: `g_i` is valid this cycle.
- `b_o`, output, WIDTH: registered binary equivalent of the last accepted `g_i`.
- `b_vld_o`, output, 1: one-cycle pulse; `b_o` was updated.
- `up_o`, output, 1: pulse with `b_vld_o`; step was +1 modulo 2^WIDTH.
- `down_o`, output, 1: pulse with `b_vld_o`; step was −1 modulo 2^WIDTH.
- `err_o`, output, 1: pulse with `b_vld_o`; illegal step (Hamming distance ≥2).
- `locked_o`, output, 1: level; the checker is in `LOCKED`.
- `err_cnt_o`, output, ERR_W: saturating count of illegal steps.

## Operation
- Conversion: `b[WIDTH-1] = g[WIDTH-1]`; `b[i] = b[i+1] ^ g[i]`.
- The previous accepted Gray code is held in `g_prev`, with its binary form in `b_prev`.
- Step classification on each `g_vld_i` (except the first sample after reset):
  - distance 0: hold. No up/down/err; `b_vld_o` still pulses; lock progress is unchanged.
  - distance 1: legal step. `up_o` if `b_new == b_prev+1` (mod 2^WIDTH), otherwise `down_o`. Wrap is legal: Gray `1000`→`0000` gives binary 15→0, `up_o`.
  - distance ≥2: `err_o`.
- State machine (`st`):
  - `EMPTY` (reset state): first valid sample loads `g_prev`/`b_prev` and pulses `b_vld_o`, with no up/down/err. Next state is `ACQUIRE` with `good_cnt=0`.
  - `ACQUIRE`: a legal step increments `good_cnt`; reaching `LOCK_CNT` moves to `LOCKED`. An error clears `good_cnt` and stays in `ACQUIRE`.
  - `LOCKED`: a legal step or hold stays in `LOCKED`. An error moves to `ACQUIRE` with `good_cnt=0`.
- Direction reversal (up then down) is legal and does not affect lock.
- An illegal sample still updates `g_prev`/`b_prev`, so the checker resynchronises to the new value.
- `err_cnt_o` increments on every `err_o` and saturates at 2^ERR_W−1.

## Timing
- Latency: `g_i` sampled at edge N appears on `b_o`, and `b_vld_o`/`up_o`/`down_o`/`err_o` pulse, after edge N+1 (1 cycle).
- The checker accepts a sample every cycle; there is no backpressure.
- `locked_o` rises in the same cycle as the `b_vld_o` of the LOCK_CNT-th legal step, and falls in the same cycle as the `err_o` that breaks lock.
- Cycles with `g_vld_i=0`: no pulses; all state holds.
- Reset values: `b_o=0`, `b_vld_o=0`, `up_o=0`, `down_o=0`, `err_o=0`, `locked_o=0`, `err_cnt_o=0`, `st=EMPTY`, `good_cnt=0`.
- Reset asserted mid-stream overrides `g_vld_i` in the same cycle. The first sample after reset is never classified as an error.
- `up_o`, `down_o` and `err_o` are mutually exclusive.

## Configuration
- `GRAY_ERR_CNT_EN` defined: the `err_cnt_o` saturating counter is implemented.
- `GRAY_ERR_CNT_EN` undefined: no counter registers; `err_cnt_o` is tied to 0. `err_o` and lock behaviour are unchanged.

## Test plan
- Reset then free-running sequence: reset 2 cycles, then feed `top`'s `g_o` sequence 0000,0001,0011,0010,… for 20 samples. Require `b_o` = 0,1,2,3,…, `up_o` on every sample except the first, `locked_o` high after the 4th sample (LOCK_CNT=3), and `err_o` never asserted.
- Wrap: feed Gray 0100 (b=7), then 1100 (b=8), …, 1000 (b=15), then 0000. Require `b_o` 15→0 with `up_o=1` and `err_o=0`.
- Down and reversal: feed 0011, 0010, 0011, 0001 (b=2,3,2,1). Require up, down, down pulses respectively and `locked_o` unaffected.
- Illegal step: while locked at 0010 (b=3), feed 0101 (b=6, distance 3). Require `err_o=1`, `locked_o` falls that cycle, `err_cnt_o=1`, and `b_o=6`. Three further legal steps relock.
- Hold and gaps: repeat 0110 twice with `g_vld_i` low for 3 cycles between samples. Require 2 `b_vld_o` pulses, no up/down/err, and unchanged `good_cnt` and `locked_o`.
- Reset mid-stream and saturation: with ERR_W=2, inject 5 errors and require `err_cnt_o` to stick at 3. Assert `rst` together with `g_vld_i` and require all outputs to be 0 next cycle. The next sample gives `b_vld_o` with no `err_o`. Without `GRAY_ERR_CNT_EN`, require `err_cnt_o=0` throughout.
